wordline_regfile: RTL and testbench
===================================

Name: wordline_regfile

Overview:
- Parametrised register file built on one-hot wordline decode. Generalises the fixed 4:16 read decoder to 2^ADDR_W entries and NUM_RD read ports.
- Adds a registered write port, optional write-to-read bypass, optional hard-wired zero register and a per-entry dirty bitmap for context-save logic.
- Sits in the decode stage of the pipelined CPU, between instruction decode and the ID/EX pipeline register.

Parameters:
- DATA_W, 16, width of each register.
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary storage.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to rd_data; 0 = the read returns the stored value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, packed; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_wordline  out  NUM_RD*DEPTH  one-hot decoded wordline for each read port (debug and verification).
- dirty  out  DEPTH  bit i set = entry i written since the last clear.
- dirty_clr  in  1  clears the dirty bitmap.
- wr_count  out  8  saturating count of accepted writes.

Behaviour:
- Decode:
  - Each address goes through a log-shifter decoder: stage j shifts by 2^j when address bit j is 1. The result is one-hot of width DEPTH.
  - Wordlines are combinational and exactly one-hot for every address value.
- Reset (rst_n = 0 at a rising edge): all entries, dirty and wr_count go to 0. rd_data then reads 0 for every address.
  - Reset wins over wr_en and dirty_clr in the same cycle.
  - If rst_n is asserted while wr_en = 1, that write is discarded.
- Write:
  - Accepted when wr_en = 1 and rst_n = 1, and not (ZERO_REG = 1 and wr_addr = 0).
  - An accepted write updates the entry at the next rising edge.
  - The write wordline uses the same decoder as the read wordlines.
- Read:
  - Combinational, zero-cycle latency from rd_addr to rd_data.
  - Forced to 0 when ZERO_REG = 1 and rd_addr = 0.
  - When BYPASS = 1, an accepted write in the current cycle and rd_addr = wr_addr: rd_data = wr_data in that same cycle.
  - When BYPASS = 0 in the same situation: rd_data = old value; the new value is visible from the next cycle.
  - All read ports may address the same entry; each returns identical data.
- Dirty bitmap:
  - An accepted write sets dirty[wr_addr] at the edge.
  - dirty_clr = 1 clears all bits at the edge.
  - If dirty_clr and an accepted write occur in the same cycle, the result is only dirty[wr_addr] = 1 (the write wins for its bit).
  - Entry 0 is never set when ZERO_REG = 1.
- wr_count:
  - Increments by 1 per accepted write.
  - Saturates at 255 and holds there; it wraps to 0 only on reset.
  - Writes rejected because of the zero register do not count.
- There is no internal state machine beyond the storage, dirty bitmap and counter. The state is fully determined by the write history since the last reset.

Test Plan:
- Reset then read: hold rst_n = 0 for 2 cycles, release, sweep every rd_addr -> rd_data = 0, dirty = 0, wr_count = 0, rd_wordline = 1 << addr for each port.
- Write/read-back with ADDR_W = 4, BYPASS = 0:
  - Write 0xA5A5 to entry 7, then read port 0 at 7 in the same cycle -> old value 0.
  - Next cycle -> 0xA5A5; dirty = 0x0080; wr_count = 1.
- Bypass with BYPASS = 1: write 0x1234 to entry 3 while port 0 and port 1 both read 3 -> both return 0x1234 in that cycle.
- Zero register with ZERO_REG = 1: write 0xFFFF to entry 0 -> reads of entry 0 stay 0, dirty[0] = 0, wr_count unchanged. With ZERO_REG = 0 the same write reads back 0xFFFF.
- Dirty and counter corner cases:
  - dirty_clr with a write to entry 5 in the same cycle -> dirty = 0x0020.
  - 300 consecutive writes -> wr_count = 255.
- Reset mid-operation: assert rst_n = 0 in the same cycle as a write of 0xBEEF to entry 9 -> after the edge, entry 9 reads 0, dirty = 0, wr_count = 0.

Source files
------------

// File: rtl/wordline_regfile.sv
// -----------------------------------------------------------------------------
// wordline_regfile
//   Multi-port register file for the decode stage. Every address (the write
//   address and each read address) goes through the same log-shifter
//   decoder, which produces a one-hot wordline that selects the entry.
//
//   Optional features:
//     - a hard-wired zero register at entry 0
//     - write-to-read bypass, so a read sees a write made in the same cycle
//     - a per-entry dirty bitmap for context-save logic
//     - a saturating counter of accepted writes
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset; clears entries, dirty and
//                wr_count
//   wr_en        write enable
//   wr_addr      write address
//   wr_data      write data
//   rd_addr      packed read addresses; port k uses [k*ADDR_W +: ADDR_W]
//   rd_data      packed combinational read data; port k uses
//                [k*DATA_W +: DATA_W]
//   rd_wordline  packed one-hot wordlines, DEPTH bits per read port
//   dirty        bit i is set when entry i has been written since the last
//                clear
//   dirty_clr    clears the dirty bitmap on the next rising edge
//   wr_count     saturating count of accepted writes (0..255)
// -----------------------------------------------------------------------------
module wordline_regfile #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
   output logic [NUM_RD*DATA_W-1:0]    rd_data,
   output logic [NUM_RD*(1<<ADDR_W)-1:0] rd_wordline,
   output logic [(1<<ADDR_W)-1:0]      dirty,
   input  logic                        dirty_clr,
   output logic [7:0]                  wr_count
);

   localparam int DEPTH = 1 << ADDR_W;

   // Log-shifter decoder. Stage j shifts the running one-hot value left by
   // 2^j when address bit j is set, so the result is always exactly one-hot.
   function automatic logic [DEPTH-1:0] decode(input logic [ADDR_W-1:0] addr);
      logic [DEPTH-1:0] wl;
      wl = {{(DEPTH-1){1'b0}}, 1'b1};
      for (int j = 0; j < ADDR_W; j++) begin
         if (addr[j]) wl = wl << (1 << j);
      end
      return wl;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  dirty_q, dirty_d;
   logic [7:0]        count_q, count_d;

   logic [DEPTH-1:0]  wr_wl;
   logic              wr_accept;

   // A write to the zero register is dropped completely: it changes no
   // storage, sets no dirty bit, does not count and is never bypassed.
   // While reset is asserted no write is accepted.
   assign wr_wl     = decode(wr_addr);
   assign wr_accept = wr_en && rst_n &&
                      !((ZERO_REG != 0) && (wr_addr == '0));

   // NOTE: each _d signal gets a full default at the top of the block, so
   // every path assigns it and no latch can be inferred.
   always_comb begin
      mem_d   = mem_q;
      dirty_d = dirty_clr ? '0 : dirty_q;
      count_d = count_q;
      if (wr_accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_wl[i]) mem_d[i] = wr_data;
         end
         // The set is applied after the clear, so when both happen in the
         // same cycle the written entry's bit ends up set.
         dirty_d = dirty_d | wr_wl;
         if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end
   end

   // NOTE: the storage array is reset along with the control state, because
   // every entry must read 0 after reset. That costs a reset on every
   // storage flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         dirty_q <= '0;
         count_q <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignments, so every flop
         // samples its _d value from before the clock edge.
         mem_q   <= mem_d;
         dirty_q <= dirty_d;
         count_q <= count_d;
      end
   end

   assign dirty    = dirty_q;
   assign wr_count = count_q;

   // Read ports: the decoded wordline selects the stored entry through an
   // AND-OR mux. The bypass and zero-register overrides are applied after
   // the mux, and the zero register takes priority.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [DEPTH-1:0]  rd_wl;
      logic [DATA_W-1:0] rd_val;

      always_comb begin
         rd_wl  = decode(rd_addr[k*ADDR_W +: ADDR_W]);
         rd_val = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_wl[i]) rd_val = rd_val | mem_q[i];
         end
         // Both wordlines are one-hot, so a non-zero AND means the read
         // address and the write address are the same.
         if ((BYPASS != 0) && wr_accept && ((rd_wl & wr_wl) != '0)) begin
            rd_val = wr_data;
         end
         if ((ZERO_REG != 0) && rd_wl[0]) rd_val = '0;
      end

      assign rd_wordline[k*DEPTH +: DEPTH]  = rd_wl;
      assign rd_data[k*DATA_W +: DATA_W]    = rd_val;
   end

endmodule

// File: tb/tb_wordline_regfile.sv
// -----------------------------------------------------------------------------
// tb_wordline_regfile
//   Two instances of the register file share one set of inputs:
//     dut_a: ZERO_REG = 1, BYPASS = 1
//     dut_b: ZERO_REG = 0, BYPASS = 0
//   The bench checks both instances with:
//     - a reset sweep over every read address
//     - a table of directed vectors with hand-computed expected values
//     - a saturation sequence for wr_count
//     - randomized traffic compared against an array-based reference model
// -----------------------------------------------------------------------------
module tb_wordline_regfile;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int NR    = 2;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [NR*AW-1:0]  rd_addr;
   logic              dirty_clr;

   logic [NR*DW-1:0]    rd_data_a, rd_data_b;
   logic [NR*DEPTH-1:0] rd_wl_a, rd_wl_b;
   logic [DEPTH-1:0]    dirty_a, dirty_b;
   logic [7:0]          cnt_a, cnt_b;

   always #5 clk = ~clk;

   wordline_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
                      .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_wordline(rd_wl_a), .dirty(dirty_a), .dirty_clr(dirty_clr),
      .wr_count(cnt_a)
   );

   wordline_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
                      .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_wordline(rd_wl_b), .dirty(dirty_b), .dirty_clr(dirty_clr),
      .wr_count(cnt_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model. Index 0 models dut_a and index 1 models dut_b.
   logic [DW-1:0]    m_mem   [2][DEPTH];
   logic [DEPTH-1:0] m_dirty [2];
   int               m_cnt   [2];

   function automatic bit has_zero(int d);
      return d == 0;
   endfunction

   function automatic bit has_bypass(int d);
      return d == 0;
   endfunction

   function automatic bit accepted(int d);
      return rst_n && wr_en && !(has_zero(d) && wr_addr == 0);
   endfunction

   function automatic logic [DW-1:0] exp_rd(int d, logic [AW-1:0] a);
      if (has_zero(d) && a == 0) return '0;
      if (has_bypass(d) && accepted(d) && a == wr_addr) return wr_data;
      return m_mem[d][a];
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Compares every output of both instances against the model. It is
   // called after the inputs have settled and before the next clock edge.
   task automatic check_all(input string tag);
      logic [NR*DW-1:0]    rdd;
      logic [NR*DEPTH-1:0] wl;
      logic [DEPTH-1:0]    dt;
      logic [7:0]          ct;
      logic [DEPTH-1:0]    one;
      logic [AW-1:0]       a;
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            rdd = rd_data_a; wl = rd_wl_a; dt = dirty_a; ct = cnt_a;
         end else begin
            rdd = rd_data_b; wl = rd_wl_b; dt = dirty_b; ct = cnt_b;
         end
         for (int k = 0; k < NR; k++) begin
            a   = rd_addr[k*AW +: AW];
            one = 1;
            check($sformatf("%s d%0d p%0d rd_data", tag, d, k),
                  64'(rdd[k*DW +: DW]), 64'(exp_rd(d, a)));
            check($sformatf("%s d%0d p%0d wordline", tag, d, k),
                  64'(wl[k*DEPTH +: DEPTH]), 64'(one << a));
         end
         check($sformatf("%s d%0d dirty", tag, d), 64'(dt), 64'(m_dirty[d]));
         check($sformatf("%s d%0d wr_count", tag, d), 64'(ct), 64'(m_cnt[d]));
      end
   endtask

   // Advances one clock edge and updates the model from the inputs that
   // were applied during the cycle.
   task automatic tick();
      bit acc [2];
      @(posedge clk);
      for (int d = 0; d < 2; d++) acc[d] = accepted(d);
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
            m_dirty[d] = '0;
            m_cnt[d]   = 0;
         end else begin
            if (dirty_clr) m_dirty[d] = '0;
            if (acc[d]) begin
               m_mem[d][wr_addr]   = wr_data;
               m_dirty[d][wr_addr] = 1'b1;
               if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
            end
         end
      end
      #1;
   endtask

   task automatic drive(input logic r, input logic we, input logic dc,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      rst_n     = r;
      wr_en     = we;
      dirty_clr = dc;
      wr_addr   = wa;
      wr_data   = wd;
      rd_addr   = {r1, r0};
      #1;
   endtask

   typedef struct {
      logic          rst_n, wr_en, dirty_clr;
      logic [AW-1:0] wr_addr, rd0, rd1;
      logic [DW-1:0] wr_data;
      logic [DW-1:0] e_a0, e_a1, e_b0, e_b1;   // same-cycle read data
      logic [DW-1:0] e_dirty_a, e_dirty_b;     // after the edge
      logic [7:0]    e_cnt_a, e_cnt_b;         // after the edge
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1,1,0, 7,7,7, 16'hA5A5, 16'hA5A5,16'hA5A5,16'h0,16'h0,      16'h0080,16'h0080, 1,1};
      vecs[1] = '{1,0,0, 0,7,0, 16'h0000, 16'hA5A5,16'h0,16'hA5A5,16'h0,      16'h0080,16'h0080, 1,1};
      vecs[2] = '{1,1,0, 3,3,3, 16'h1234, 16'h1234,16'h1234,16'h0,16'h0,      16'h0088,16'h0088, 2,2};
      vecs[3] = '{1,1,0, 0,0,3, 16'hFFFF, 16'h0,16'h1234,16'h0,16'h1234,      16'h0088,16'h0089, 2,3};
      vecs[4] = '{1,0,0, 0,0,0, 16'h0000, 16'h0,16'h0,16'hFFFF,16'hFFFF,      16'h0088,16'h0089, 2,3};
      vecs[5] = '{1,1,1, 5,5,7, 16'h0055, 16'h0055,16'hA5A5,16'h0,16'hA5A5,   16'h0020,16'h0020, 3,4};
      vecs[6] = '{0,1,0, 9,9,7, 16'hBEEF, 16'h0,16'hA5A5,16'h0,16'hA5A5,      16'h0000,16'h0000, 0,0};
      vecs[7] = '{1,0,0, 0,9,7, 16'h0000, 16'h0,16'h0,16'h0,16'h0,            16'h0000,16'h0000, 0,0};

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
         m_dirty[d] = '0;
         m_cnt[d]   = 0;
      end

      // Reset held for two cycles, then every read address is swept.
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      for (int a = 0; a < DEPTH; a++) begin
         drive(1, 0, 0, 0, 0, AW'(a), AW'(DEPTH - 1 - a));
         check_all($sformatf("reset_sweep a%0d", a));
      end

      // Directed vectors.
      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].rst_n, vecs[v].wr_en, vecs[v].dirty_clr,
               vecs[v].wr_addr, vecs[v].wr_data, vecs[v].rd0, vecs[v].rd1);
         check($sformatf("vec%0d a rd0", v), 64'(rd_data_a[15:0]),  64'(vecs[v].e_a0));
         check($sformatf("vec%0d a rd1", v), 64'(rd_data_a[31:16]), 64'(vecs[v].e_a1));
         check($sformatf("vec%0d b rd0", v), 64'(rd_data_b[15:0]),  64'(vecs[v].e_b0));
         check($sformatf("vec%0d b rd1", v), 64'(rd_data_b[31:16]), 64'(vecs[v].e_b1));
         check_all($sformatf("vec%0d model", v));
         tick();
         check($sformatf("vec%0d a dirty", v), 64'(dirty_a), 64'(vecs[v].e_dirty_a));
         check($sformatf("vec%0d b dirty", v), 64'(dirty_b), 64'(vecs[v].e_dirty_b));
         check($sformatf("vec%0d a cnt", v),   64'(cnt_a),   64'(vecs[v].e_cnt_a));
         check($sformatf("vec%0d b cnt", v),   64'(cnt_b),   64'(vecs[v].e_cnt_b));
      end

      // 300 consecutive writes drive wr_count into saturation.
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 300; i++) begin
         drive(1, 1, 0, AW'(1 + (i % 15)), DW'(i), AW'(i % 16), 4'd1);
         tick();
      end
      drive(1, 0, 0, 0, 0, 2, 15);
      check("sat a wr_count", 64'(cnt_a), 64'd255);
      check("sat b wr_count", 64'(cnt_b), 64'd255);
      check_all("sat model");

      // Randomized traffic checked against the model.
      for (int c = 0; c < 600; c++) begin
         logic [AW-1:0] wa, r0, r1;
         wa = AW'($urandom_range(DEPTH - 1));
         r0 = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(DEPTH - 1));
         r1 = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(DEPTH - 1));
         drive(($urandom_range(63) != 0), ($urandom_range(3) != 0),
               ($urandom_range(15) == 0), wa, DW'($urandom), r0, r1);
         check_all($sformatf("rand c%0d", c));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
